// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with store lane alignment and misaligned-access squash
module ex_mem_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [31:0]      ex_aluresult,
  input  logic [31:0]      ex_writedata,
  input  logic [4:0]       ex_rd,
  input  logic [31:0]      ex_pcplus4,
  input  logic             ex_regwrite,
  input  logic [1:0]       ex_resultsrc,
  input  logic             ex_memwrite,
  input  logic             ex_memread,
  input  logic [2:0]       ex_funct3,
  output logic             mem_valid,
  output logic [31:0]      mem_aluresult,
  output logic [31:0]      mem_writedata,
  output logic [3:0]       mem_wbe,
  output logic             mem_memwrite,
  output logic [4:0]       mem_rd,
  output logic [31:0]      mem_pcplus4,
  output logic             mem_regwrite,
  output logic [1:0]       mem_resultsrc,
  output logic [2:0]       mem_funct3,
  output logic [1:0]       mem_byteoff,
  output logic             mem_misaligned,
  output logic [CNT_W-1:0] misaligned_count
);
  logic [1:0]  a;
  logic        smis, lmis, mis, we;
  logic [31:0] wdata;
  logic [3:0]  lanes;
  // Classify the access: illegal store sizes count as misaligned, odd load sizes never do
  always_comb begin
    a     = ex_aluresult[1:0];
    smis  = ex_funct3 == 3'b000 ? 1'b0 : ex_funct3 == 3'b001 ? a[0] : ex_funct3 == 3'b010 ? |a : 1'b1;
    lmis  = (ex_funct3 == 3'b001 || ex_funct3 == 3'b101) ? a[0] : ex_funct3 == 3'b010 ? |a : 1'b0;
    mis   = ex_valid & ((ex_memwrite & smis) | (ex_memread & lmis));
    we    = ex_valid & ex_memwrite & ~mis;
    lanes = ex_funct3 == 3'b000 ? 4'b0001 << a : ex_funct3 == 3'b001 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = !ex_memwrite ? ex_writedata :
            ex_funct3 == 3'b000 ? {4{ex_writedata[7:0]}} :
            ex_funct3 == 3'b001 ? {2{ex_writedata[15:0]}} : ex_writedata;
  end
  // Pipeline register: flush bubbles everything but the counter, stall holds, else capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid        <= 1'b0;
      mem_aluresult    <= '0;
      mem_writedata    <= '0;
      mem_wbe          <= '0;
      mem_memwrite     <= 1'b0;
      mem_rd           <= '0;
      mem_pcplus4      <= '0;
      mem_regwrite     <= 1'b0;
      mem_resultsrc    <= '0;
      mem_funct3       <= '0;
      mem_byteoff      <= '0;
      mem_misaligned   <= 1'b0;
      misaligned_count <= '0;
    end else if (flush) begin
      mem_valid        <= 1'b0;
      mem_aluresult    <= '0;
      mem_writedata    <= '0;
      mem_wbe          <= '0;
      mem_memwrite     <= 1'b0;
      mem_rd           <= '0;
      mem_pcplus4      <= '0;
      mem_regwrite     <= 1'b0;
      mem_resultsrc    <= '0;
      mem_funct3       <= '0;
      mem_byteoff      <= '0;
      mem_misaligned   <= 1'b0;
    end else if (!stall) begin
      mem_valid        <= ex_valid;
      mem_aluresult    <= ex_aluresult;
      mem_writedata    <= wdata;
      mem_wbe          <= we ? lanes : 4'b0000;
      mem_memwrite     <= we;
      mem_rd           <= ex_rd;
      mem_pcplus4      <= ex_pcplus4;
      mem_regwrite     <= ex_regwrite & ex_valid & ~mis;
      mem_resultsrc    <= ex_resultsrc;
      mem_funct3       <= ex_funct3;
      mem_byteoff      <= a;
      mem_misaligned   <= mis;
      if (mis && !(&misaligned_count)) misaligned_count <= misaligned_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: randomized and directed checks of ex_mem_reg against a behavioural model
module tb_ex_mem_reg;
  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [3:0]  wbe;
    logic        mw;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        rw;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [1:0]  bo;
    logic        mis;
  } out_t;

  logic clk = 0, reset = 1, stall = 0, flush = 0;
  logic ex_valid = 0, ex_regwrite = 0, ex_memwrite = 0, ex_memread = 0;
  logic [31:0] ex_aluresult = 0, ex_writedata = 0, ex_pcplus4 = 0;
  logic [4:0] ex_rd = 0;
  logic [1:0] ex_resultsrc = 0;
  logic [2:0] ex_funct3 = 0;

  logic mem_valid, mem_memwrite, mem_regwrite, mem_misaligned;
  logic [31:0] mem_aluresult, mem_writedata, mem_pcplus4;
  logic [3:0] mem_wbe;
  logic [4:0] mem_rd;
  logic [1:0] mem_resultsrc, mem_byteoff;
  logic [2:0] mem_funct3;
  logic [15:0] misaligned_count;

  logic s_valid, s_memwrite, s_regwrite, s_misaligned;
  logic [31:0] s_aluresult, s_writedata, s_pcplus4;
  logic [3:0] s_wbe;
  logic [4:0] s_rd;
  logic [1:0] s_resultsrc, s_byteoff;
  logic [2:0] s_funct3;
  logic [1:0] s_count;

  out_t got, exp;
  int   cnt, cnt2;
  int   checks = 0, errors = 0;

  assign got = {mem_valid, mem_aluresult, mem_writedata, mem_wbe, mem_memwrite, mem_rd,
                mem_pcplus4, mem_regwrite, mem_resultsrc, mem_funct3, mem_byteoff, mem_misaligned};

  always #5 clk = ~clk;

  ex_mem_reg #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_aluresult(ex_aluresult), .ex_writedata(ex_writedata), .ex_rd(ex_rd),
    .ex_pcplus4(ex_pcplus4), .ex_regwrite(ex_regwrite), .ex_resultsrc(ex_resultsrc),
    .ex_memwrite(ex_memwrite), .ex_memread(ex_memread), .ex_funct3(ex_funct3),
    .mem_valid(mem_valid), .mem_aluresult(mem_aluresult), .mem_writedata(mem_writedata),
    .mem_wbe(mem_wbe), .mem_memwrite(mem_memwrite), .mem_rd(mem_rd), .mem_pcplus4(mem_pcplus4),
    .mem_regwrite(mem_regwrite), .mem_resultsrc(mem_resultsrc), .mem_funct3(mem_funct3),
    .mem_byteoff(mem_byteoff), .mem_misaligned(mem_misaligned), .misaligned_count(misaligned_count));

  // Narrow-counter instance exposes saturation within a few captures
  ex_mem_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_aluresult(ex_aluresult), .ex_writedata(ex_writedata), .ex_rd(ex_rd),
    .ex_pcplus4(ex_pcplus4), .ex_regwrite(ex_regwrite), .ex_resultsrc(ex_resultsrc),
    .ex_memwrite(ex_memwrite), .ex_memread(ex_memread), .ex_funct3(ex_funct3),
    .mem_valid(s_valid), .mem_aluresult(s_aluresult), .mem_writedata(s_writedata),
    .mem_wbe(s_wbe), .mem_memwrite(s_memwrite), .mem_rd(s_rd), .mem_pcplus4(s_pcplus4),
    .mem_regwrite(s_regwrite), .mem_resultsrc(s_resultsrc), .mem_funct3(s_funct3),
    .mem_byteoff(s_byteoff), .mem_misaligned(s_misaligned), .misaligned_count(s_count));

  function automatic out_t model_capture();
    out_t o;
    int a, ssz, lsz;
    bit smis, lmis, mis;
    a    = int'(ex_aluresult % 4);
    ssz  = ex_funct3 <= 2 ? (1 << ex_funct3) : 0;
    lsz  = (ex_funct3 == 1 || ex_funct3 == 5) ? 2 : ex_funct3 == 2 ? 4 : 1;
    smis = ssz == 0 || (a % ssz) != 0;
    lmis = (a % lsz) != 0;
    mis  = ex_valid && ((ex_memwrite && smis) || (ex_memread && lmis));
    o.valid = ex_valid;
    o.alu   = ex_aluresult;
    o.wd    = !ex_memwrite ? ex_writedata : ex_funct3 == 0 ? ex_writedata[7:0] * 32'h01010101 :
              ex_funct3 == 1 ? ex_writedata[15:0] * 32'h00010001 : ex_writedata;
    o.mw    = ex_valid && ex_memwrite && !mis;
    o.wbe   = o.mw ? 4'(((1 << ssz) - 1) << a) : 4'b0000;
    o.rd    = ex_rd;
    o.pc    = ex_pcplus4;
    o.rw    = ex_valid && ex_regwrite && !mis;
    o.rs    = ex_resultsrc;
    o.f3    = ex_funct3;
    o.bo    = 2'(a);
    o.mis   = mis;
    return o;
  endfunction

  task automatic tick();
    out_t n;
    n = model_capture();
    if (flush) exp = '0;
    else if (!stall) begin
      if (n.mis) begin
        cnt  = cnt == 65535 ? cnt : cnt + 1;
        cnt2 = cnt2 == 3 ? cnt2 : cnt2 + 1;
      end
      exp = n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] wd, input logic rw,
                        input logic mw, input logic mr, input logic [2:0] f3);
    ex_valid = v; ex_aluresult = alu; ex_writedata = wd; ex_regwrite = rw;
    ex_memwrite = mw; ex_memread = mr; ex_funct3 = f3;
    ex_rd = 5'($urandom); ex_pcplus4 = $urandom; ex_resultsrc = 2'($urandom_range(0, 2));
  endtask

  task automatic do_reset();
    stall = 0; flush = 0;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    exp = '0; cnt = 0; cnt2 = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (got !== '0 || misaligned_count !== 16'd0) begin
      errors++; $display("FAIL reset_init got=%h cnt=%h want all zero", got, misaligned_count);
    end
    set_ex(1, 32'h201, 32'hDEADBEEF, 1, 1, 0, 3'b010);
    tick();
    set_ex(1, 32'h100, 32'h1, 1, 0, 0, 3'b000);
    tick();
    stall = 1;
    tick();
    #2 reset = 1;
    #1;
    checks++;
    if (got !== '0 || misaligned_count !== 16'd0 || s_count !== 2'd0) begin
      errors++; $display("FAIL reset_midstall got=%h cnt=%h want all zero before edge", got, misaligned_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (got !== '0 || misaligned_count !== 16'd0) begin
      errors++; $display("FAIL reset_hold got=%h cnt=%h want all zero", got, misaligned_count);
    end
    do_reset();
  endtask

  task automatic test_store();
    do_reset();
    set_ex(1, 32'h103, 32'h000000A5, 0, 1, 0, 3'b000);
    tick();
    checks++;
    if (mem_writedata !== 32'hA5A5A5A5 || mem_wbe !== 4'b1000 || mem_memwrite !== 1'b1 || mem_misaligned !== 1'b0) begin
      errors++; $display("FAIL sb wd=%h wbe=%b mw=%b mis=%b want a5a5a5a5 1000 1 0", mem_writedata, mem_wbe, mem_memwrite, mem_misaligned);
    end
    set_ex(1, 32'h202, 32'h1234BEEF, 0, 1, 0, 3'b001);
    tick();
    checks++;
    if (mem_writedata !== 32'hBEEFBEEF || mem_wbe !== 4'b1100 || mem_memwrite !== 1'b1) begin
      errors++; $display("FAIL sh wd=%h wbe=%b mw=%b want beefbeef 1100 1", mem_writedata, mem_wbe, mem_memwrite);
    end
    set_ex(1, 32'h201, 32'h11223344, 0, 1, 0, 3'b010);
    tick();
    checks++;
    if (mem_memwrite !== 1'b0 || mem_wbe !== 4'b0000 || mem_misaligned !== 1'b1 || misaligned_count !== 16'd1) begin
      errors++; $display("FAIL sw_mis mw=%b wbe=%b mis=%b cnt=%0d want 0 0000 1 1", mem_memwrite, mem_wbe, mem_misaligned, misaligned_count);
    end
    set_ex(1, 32'h200, 32'h11223344, 0, 1, 0, 3'b011);
    tick();
    checks++;
    if (mem_memwrite !== 1'b0 || mem_wbe !== 4'b0000 || mem_misaligned !== 1'b1 || misaligned_count !== 16'd2) begin
      errors++; $display("FAIL store_illegal mw=%b wbe=%b mis=%b cnt=%0d want 0 0000 1 2", mem_memwrite, mem_wbe, mem_misaligned, misaligned_count);
    end
  endtask

  task automatic test_load();
    do_reset();
    set_ex(1, 32'h006, 32'h5, 1, 0, 1, 3'b010);
    tick();
    checks++;
    if (mem_regwrite !== 1'b0 || mem_misaligned !== 1'b1 || mem_wbe !== 4'b0000 || misaligned_count !== 16'd1) begin
      errors++; $display("FAIL lw_mis rw=%b mis=%b wbe=%b cnt=%0d want 0 1 0000 1", mem_regwrite, mem_misaligned, mem_wbe, misaligned_count);
    end
    set_ex(1, 32'h007, 32'h5, 1, 0, 1, 3'b100);
    tick();
    checks++;
    if (mem_regwrite !== 1'b1 || mem_byteoff !== 2'b11 || mem_funct3 !== 3'b100 || mem_misaligned !== 1'b0 || mem_wbe !== 4'b0000) begin
      errors++; $display("FAIL lbu rw=%b bo=%b f3=%b mis=%b wbe=%b want 1 11 100 0 0000", mem_regwrite, mem_byteoff, mem_funct3, mem_misaligned, mem_wbe);
    end
    set_ex(0, 32'h003, 32'h77, 1, 1, 0, 3'b010);
    tick();
    checks++;
    if (mem_valid !== 1'b0 || mem_regwrite !== 1'b0 || mem_memwrite !== 1'b0 || mem_misaligned !== 1'b0 || mem_aluresult !== 32'h3 || misaligned_count !== 16'd1) begin
      errors++; $display("FAIL invalid_capture v=%b rw=%b mw=%b mis=%b alu=%h cnt=%0d want 0 0 0 0 3 1", mem_valid, mem_regwrite, mem_memwrite, mem_misaligned, mem_aluresult, misaligned_count);
    end
  endtask

  task automatic test_stall();
    out_t snap;
    logic [15:0] c;
    do_reset();
    set_ex(1, 32'h301, 32'hCAFE, 1, 1, 0, 3'b001);
    tick();
    snap = got; c = misaligned_count;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_ex(1, $urandom, $urandom, 1, 1, 0, 3'b010);
      ex_aluresult[0] = 1'b1;
      tick();
      checks++;
      if (got !== snap || misaligned_count !== c) begin
        errors++; $display("FAIL stall_hold%0d got=%h cnt=%0d want %h %0d", i, got, misaligned_count, snap, c);
      end
    end
    flush = 1;
    set_ex(1, 32'h100, 32'h1, 1, 1, 0, 3'b010);
    tick();
    checks++;
    if (got !== '0 || misaligned_count !== c) begin
      errors++; $display("FAIL stall_flush got=%h cnt=%0d want bubble cnt %0d", got, misaligned_count, c);
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_saturate();
    do_reset();
    set_ex(1, 32'h201, 32'h1, 0, 1, 0, 3'b010);
    tick(); tick();
    checks++;
    if (s_count !== 2'd2 || misaligned_count !== 16'd2) begin
      errors++; $display("FAIL sat_preload cnt2=%0d cnt=%0d want 2 2", s_count, misaligned_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_count !== 2'd3 || misaligned_count !== 16'(3 + i)) begin
        errors++; $display("FAIL sat_step%0d cnt2=%0d cnt=%0d want 3 %0d", i, s_count, misaligned_count, 3 + i);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stall = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 9) == 0;
      set_ex($urandom_range(0, 7) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      tick();
      checks++;
      if (got !== exp || misaligned_count !== 16'(cnt) || s_count !== 2'(cnt2)) begin
        errors++; $display("FAIL rand%0d got=%h cnt=%0d cnt2=%0d want %h %0d %0d", i, got, misaligned_count, s_count, exp, cnt, cnt2);
      end
    end
    stall = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_stall();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
